// File: rtl/padder_pkg.sv
// Shared types, default geometry and helpers for the multi-rate input padder.
package padder_pkg;

    typedef enum logic [1:0] {
        ABSORB,
        PAD,
        WAIT_LAST
    } state_t;

    // Default geometry (SHA3-256 rate with 32-bit words)
    localparam int RATE_BITS_DEF = 1088;
    localparam int IN_W_DEF      = 32;
    localparam int WORDS         = RATE_BITS_DEF / IN_W_DEF;
    localparam int CNT_W         = $clog2(WORDS + 1);

    // Widest word supported by the byte mask (IN_W < 8*MAX_BYTES)
    localparam int MAX_BYTES = 64;

    // Bit i set when byte i (counted from the MS byte) carries message data
    function automatic logic [MAX_BYTES-1:0] byte_mask(input int byte_num);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < byte_num);
        end
        return m;
    endfunction

endpackage

// File: rtl/padder_word.sv
// Builds the final message word: valid bytes, then the domain byte, then zeros,
// with the 0x80 end-of-block marker ORed into the LS byte when the word fills the block.
module padder_word
    import padder_pkg::*;
#(
    parameter int          IN_W   = 32,
    parameter logic [7:0]  DSBYTE = 8'h06,
    localparam int         NB     = IN_W / 8,
    localparam int         BNW    = $clog2(NB)
) (
    input  logic [IN_W-1:0] in,
    input  logic [BNW-1:0]  byte_num,
    input  logic            last_in_block,
    output logic [IN_W-1:0] w
);

    logic [MAX_BYTES-1:0] mask;
    logic                 unused_mask;

    assign mask        = byte_mask(int'(byte_num));
    assign unused_mask = ^mask[MAX_BYTES-1:NB];

    for (genvar i = 0; i < NB; i++) begin : g_byte
        logic [7:0] b;

        // Select message byte, domain byte or zero for byte lane i
        always_comb begin
            if (mask[i])
                b = in[IN_W-1-8*i -: 8];
            else if (byte_num == BNW'(i))
                b = DSBYTE;
            else
                b = 8'h00;
        end

        if (i == NB - 1) begin : g_ls
            assign w[7:0] = b | (last_in_block ? 8'h80 : 8'h00);
        end else begin : g_ms
            assign w[IN_W-1-8*i -: 8] = b;
        end
    end

endmodule

// File: rtl/padder_gen.sv
// Multi-rate padder: collects words into a rate-sized block, pads the final block
// and hands each full block to the permutation; returns to absorbing after the last ack.
module padder_gen
    import padder_pkg::*;
#(
    parameter int          RATE_BITS = 1088,
    parameter int          IN_W      = 32,
    parameter logic [7:0]  DSBYTE    = 8'h06,
    localparam int         NW        = RATE_BITS / IN_W,
    localparam int         CW        = $clog2(NW + 1),
    localparam int         BNW       = $clog2(IN_W / 8)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IN_W-1:0]      in,
    input  logic                 in_ready,
    input  logic                 is_last,
    input  logic [BNW-1:0]       byte_num,
    output logic                 in_accept,
    output logic                 buffer_full,
    output logic [RATE_BITS-1:0] out,
    output logic                 out_ready,
    output logic                 out_last,
    input  logic                 f_ack
);

    state_t          state;
    logic [CW-1:0]   count;
    logic            full;
    logic            last_slot;
    logic [IN_W-1:0] pad_w;
    logic [IN_W-1:0] w;

    assign full        = (count == CW'(NW));
    assign last_slot   = (count == CW'(NW - 1));
    assign buffer_full = full;
    assign out_ready   = full;
    assign in_accept   = reset_n & (state == ABSORB) & in_ready & ~full;

    padder_word #(
        .IN_W   (IN_W),
        .DSBYTE (DSBYTE)
    ) u_word (
        .in            (in),
        .byte_num      (byte_num),
        .last_in_block (last_slot),
        .w             (pad_w)
    );

    // Word to shift in: raw data, the pad word, or pure padding
    always_comb begin
        w = '0;
        if (state == ABSORB)
            w = is_last ? pad_w : in;
        else if (last_slot)
            w = IN_W'(8'h80);
    end

    // Block FSM, word counter and shift buffer; out_last rises with the final fill
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out      <= '0;
            count    <= '0;
            state    <= ABSORB;
            out_last <= 1'b0;
        end else begin
            case (state)
                ABSORB: begin
                    if (full) begin
                        if (f_ack) count <= '0;
                    end else if (in_ready) begin
                        out   <= {out[RATE_BITS-IN_W-1:0], w};
                        count <= count + CW'(1);
                        if (is_last) begin
                            if (last_slot) begin
                                out_last <= 1'b1;
                                state    <= WAIT_LAST;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    if (!full) begin
                        out   <= {out[RATE_BITS-IN_W-1:0], w};
                        count <= count + CW'(1);
                        if (last_slot) begin
                            out_last <= 1'b1;
                            state    <= WAIT_LAST;
                        end
                    end else begin
                        out_last <= 1'b1;
                        state    <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (f_ack && full) begin
                        count    <= '0;
                        out_last <= 1'b0;
                        state    <= ABSORB;
                    end
                end
                default: state <= ABSORB;
            endcase
        end
    end

endmodule

// File: tb/tb_padder_gen.sv
// Random-message bench for padder_gen, checked against a byte-level padding model.
module tb_padder_gen;

    localparam int WORDS = 34;
    localparam int RBY   = 136;

    typedef logic [7:0] bq_t[$];

    logic          clk;
    logic          reset_n;
    logic [31:0]   d_in;
    logic          in_ready;
    logic          is_last;
    logic [1:0]    byte_num;
    logic          in_accept;
    logic          buffer_full;
    logic [1087:0] d_out;
    logic          out_ready;
    logic          out_last;
    logic          f_ack;

    logic [63:0]   in64;
    logic          in_ready64;
    logic          is_last64;
    logic [2:0]    bn64;
    logic          acc64;
    logic          full64;
    logic [575:0]  out64;
    logic          ordy64;
    logic          last64;
    logic          f_ack64;

    int errs;
    int checks;
    int cyc;
    int last_acc_cyc;
    int exp_lat;
    bit mon_en;

    logic [1087:0] exp_blk[$];
    bit            exp_lst[$];

    padder_gen u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (d_in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .in_accept   (in_accept),
        .buffer_full (buffer_full),
        .out         (d_out),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .f_ack       (f_ack)
    );

    padder_gen #(.RATE_BITS(576), .IN_W(64), .DSBYTE(8'h1F)) u_dut64 (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in64),
        .in_ready    (in_ready64),
        .is_last     (is_last64),
        .byte_num    (bn64),
        .in_accept   (acc64),
        .buffer_full (full64),
        .out         (out64),
        .out_ready   (ordy64),
        .out_last    (last64),
        .f_ack       (f_ack64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [1087:0] got, input logic [1087:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: message bytes, domain byte, zero fill to the rate, 0x80 ORed into the last byte
    function automatic bq_t pad_msg(input bq_t m, input int rb, input logic [7:0] ds);
        bq_t p;
        p = m;
        p.push_back(ds);
        while (p.size() % rb != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        return p;
    endfunction

    function automatic logic [1087:0] pack_blk(input bq_t p, input int off, input int rb);
        logic [1087:0] v;
        v = '0;
        for (int j = 0; j < rb; j++) v = {v[1079:0], p[off+j]};
        return v;
    endfunction

    task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] bn, input int lat);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            in_ready = 1'b0;
            is_last  = 1'b1;
            d_in     = $urandom;
            @(negedge clk);
        end
        d_in     = d;
        is_last  = last;
        byte_num = bn;
        in_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (in_accept) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (last) begin
            last_acc_cyc = cyc;
            exp_lat      = lat;
        end
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic send_msg(input bq_t m);
        bq_t         p;
        int          nblk;
        int          nfull;
        int          r;
        logic [31:0] d;
        p     = pad_msg(m, RBY, 8'h06);
        nblk  = p.size() / RBY;
        for (int b = 0; b < nblk; b++) begin
            exp_blk.push_back(pack_blk(p, b * RBY, RBY));
            exp_lst.push_back(b == nblk - 1);
        end
        nfull = m.size() / 4;
        r     = m.size() % 4;
        for (int i = 0; i < nfull; i++)
            send_word({m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]}, 1'b0, 2'($urandom), 0);
        d = $urandom;
        for (int j = 0; j < r; j++) d[31-8*j -: 8] = m[4*nfull+j];
        send_word(d, 1'b1, 2'(r), WORDS - 1 - (nfull % WORDS));
    endtask

    // Block monitor: checks each presented block once, then acks after a random delay
    initial begin
        int            dly;
        bit            seen;
        bit            l;
        logic [1087:0] e;
        dly   = 0;
        seen  = 1'b0;
        f_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (f_ack) begin
                f_ack = 1'b0;
                seen  = 1'b0;
            end else if (mon_en && reset_n && buffer_full) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_blk.size() == 0) begin
                        chk("unexpected_block", 1, 0);
                    end else begin
                        e = exp_blk.pop_front();
                        l = exp_lst.pop_front();
                        chk("block", d_out, e);
                        chk("out_last", out_last, l);
                        chk("out_ready", out_ready, 1);
                        if (l) chk("latency", cyc - last_acc_cyc, exp_lat);
                    end
                    dly = $urandom_range(0, 3);
                end
                if (in_ready) chk("hold_while_full", in_accept, 0);
                if (dly == 0) f_ack = 1'b1;
                else dly--;
            end
        end
    end

    initial begin
        bq_t m;
        bit  ok;
        errs       = 0;
        checks     = 0;
        mon_en     = 1'b0;
        reset_n    = 1'b0;
        in_ready   = 1'b1;
        is_last    = 1'b0;
        byte_num   = '0;
        d_in       = '0;
        in64       = '0;
        in_ready64 = 1'b0;
        is_last64  = 1'b0;
        bn64       = '0;
        f_ack64    = 1'b0;
        last_acc_cyc = 0;
        exp_lat      = 0;

        #1;
        chk("rst_out", d_out, 0);
        chk("rst_full", buffer_full, 0);
        chk("rst_oready", out_ready, 0);
        chk("rst_olast", out_last, 0);
        chk("rst_accept", in_accept, 0);
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        in_ready = 1'b0;

        // Wide-word, short-rate instance with SHAKE domain byte
        m = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        @(negedge clk);
        in64       = 64'h11223344_55AABBCC;
        is_last64  = 1'b1;
        bn64       = 3'd5;
        in_ready64 = 1'b1;
        #1;
        chk("acc64", acc64, 1);
        @(posedge clk);
        #1;
        in_ready64 = 1'b0;
        is_last64  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (full64) begin
                ok = 1'b1;
                break;
            end
        end
        chk("full64_seen", ok, 1);
        chk("block64", {512'b0, out64}, pack_blk(pad_msg(m, 72, 8'h1F), 0, 72));
        chk("w0_64", out64[575:512], 64'h11223344_551F0000);
        chk("w8_64", out64[63:0], 64'h80);
        chk("last64", last64, 1);

        // Async reset while padding discards the partial block
        for (int i = 0; i < 9; i++) send_word($urandom, 1'b0, 2'd0, 0);
        send_word(32'hDEADBEEF, 1'b1, 2'd2, 0);
        repeat (3) @(posedge clk);
        #2;
        reset_n  = 1'b0;
        in_ready = 1'b1;
        #1;
        chk("mid_rst_out", d_out, 0);
        chk("mid_rst_full", buffer_full, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_acc", in_accept, 0);
        reset_n  = 1'b1;
        in_ready = 1'b0;
        mon_en   = 1'b1;

        @(negedge clk);
        in_ready = 1'b1;
        #1;
        chk("acc_follow_1", in_accept, 1);
        in_ready = 1'b0;
        #1;
        chk("acc_follow_0", in_accept, 0);

        // Empty message, two back-to-back "abc", last word in final slot, exact rate
        m = {};
        send_msg(m);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        send_msg(m);
        m = {};
        for (int i = 0; i < 132; i++) m.push_back(8'h01);
        m.push_back(8'hAA);
        m.push_back(8'hBB);
        m.push_back(8'hCC);
        send_msg(m);
        m = {};
        for (int i = 0; i < 136; i++) m.push_back(8'($urandom));
        send_msg(m);

        for (int t = 0; t < 20; t++) begin
            int len;
            len = $urandom_range(0, 300);
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m);
        end

        for (int i = 0; i < 3000 && exp_blk.size() != 0; i++) @(negedge clk);
        chk("drain", exp_blk.size(), 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
